// File: rtl/sel_demux_ff.sv
// Registered 1-to-2 stream demultiplexer: in_sel steers each accepted word into
// one of two independent per-channel FIFOs, each drained by its own consumer.
module sel_demux_ff #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out0_level,
  output logic [$clog2(DEPTH):0]   out1_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    wr_ptr_d [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [AW-1:0]    rd_ptr_d [2];
  logic [LW-1:0]    level_q  [2];
  logic [LW-1:0]    level_d  [2];
  logic [1:0]       full_s;
  logic [1:0]       valid_s;
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       rdy_s;
  logic             sel_s;

  // Channel select (unknown select resolves to channel 0), handshakes and next-state
  always_comb begin
    sel_s    = (in_sel === 1'b1);
    rdy_s    = {out1_ready, out0_ready};
    full_s   = 2'b00;
    valid_s  = 2'b00;
    push_s   = 2'b00;
    pop_s    = 2'b00;
    for (int c = 0; c < 2; c++) begin
      full_s[c]  = (level_q[c] == LW'(DEPTH));
      valid_s[c] = (level_q[c] != {LW{1'b0}});
    end
    // Acceptance depends only on the target channel's occupancy, never on in_valid
    in_ready = !full_s[sel_s];
    for (int c = 0; c < 2; c++) begin
      push_s[c]   = in_valid && in_ready && (sel_s == 1'(c));
      pop_s[c]    = valid_s[c] && rdy_s[c];
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      level_d[c]  = level_q[c];
      if (push_s[c]) begin
        wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c];
      end
      if (pop_s[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
      end else begin
        rd_ptr_d[c] = rd_ptr_q[c];
      end
      case ({push_s[c], pop_s[c]})
        2'b10:   level_d[c] = level_q[c] + LW'(1);
        2'b01:   level_d[c] = level_q[c] - LW'(1);
        default: level_d[c] = level_q[c];
      endcase
    end
  end

  // Head words are presented straight from storage; an empty channel shows zero
  always_comb begin
    out0_valid = valid_s[0];
    out1_valid = valid_s[1];
    out0_level = level_q[0];
    out1_level = level_q[1];
    if (valid_s[0]) begin
      out0_data = mem_q[0][rd_ptr_q[0]];
    end else begin
      out0_data = {WIDTH{1'b0}};
    end
    if (valid_s[1]) begin
      out1_data = mem_q[1][rd_ptr_q[1]];
    end else begin
      out1_data = {WIDTH{1'b0}};
    end
  end

  // Pointer, level and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= {AW{1'b0}};
        rd_ptr_q[c] <= {AW{1'b0}};
        level_q[c]  <= {LW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= {WIDTH{1'b0}};
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        level_q[c]  <= level_d[c];
        if (push_s[c]) begin
          mem_q[c][wr_ptr_q[c]] <= in_data;
        end
      end
    end
  end

endmodule
